poly_reg_bank_db: RTL

Double-buffered AMNS operand/result register bank, the successor to the single-bank polynomial register bank. It sits between the host word stream and the DSP multiply-reduce datapath, and is parametrised in word width, polynomial degree and block count. Operands A and B for the next multiplication stream into a shadow bank over a valid/ready handshake while the datapath consumes the active bank. Results stream out through a staged output buffer.

---
 rtl/poly_reg_bank_db_if.sv | 23 ++
 rtl/poly_reg_bank_db.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_reg_bank_db_if.sv
// Host-side word stream (operand input) and result output stream of poly_reg_bank_db.
interface poly_reg_bank_db_if #(
   parameter int unsigned WORD_WIDTH = 17
);
   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            in_sel;
   logic [WORD_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [WORD_WIDTH-1:0] out_data;
   logic                  out_last;

   modport master (
      output in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/poly_reg_bank_db.sv
// Double-buffered AMNS operand/result register bank: shadow A/B banks load from the
// host stream while the datapath works on the active banks; results leave through a
// staging buffer and an output buffer.
module poly_reg_bank_db #(
   parameter int unsigned WORD_WIDTH = 17,
   parameter int unsigned N          = 5,
   parameter int unsigned S          = 4
) (
   input  logic                    clock_i,
   input  logic                    reset_n_i,
   poly_reg_bank_db_if.slave       bus,
   output logic                    shadow_full_o,
   input  logic                    swap_i,
   output logic                    swap_ack_o,
   input  logic [S-1:0]            A_reg_coeff_rot_i,
   input  logic                    B_reg_shift_i,
   input  logic                    M_reg_rot_i,
   input  logic                    M_prime_0_rot_i,
   output logic [S*WORD_WIDTH-1:0] A_reg_dout_o,
   output logic [N*WORD_WIDTH-1:0] B_reg_dout_o,
   output logic [WORD_WIDTH-1:0]   M_reg_dout_o,
   output logic [WORD_WIDTH-1:0]   M_prime_0_reg_dout_o,
   input  logic                    res_load_en_i,
   input  logic [N*WORD_WIDTH-1:0] res_din_i,
   output logic                    res_ready_o
);

   localparam int unsigned NS     = N * S;
   localparam int unsigned IDX_W  = $clog2(NS);
   localparam int unsigned MP_W   = $clog2(N);
   localparam int unsigned RCNT_W = $clog2(S + 1);

   localparam logic [1:0] SEL_A  = 2'b00;
   localparam logic [1:0] SEL_B  = 2'b01;
   localparam logic [1:0] SEL_M  = 2'b10;
   localparam logic [1:0] SEL_MP = 2'b11;

   typedef logic [WORD_WIDTH-1:0] word_t;
   typedef enum logic {ST_IDLE, ST_LOAD} load_state_e;

   load_state_e       state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [IDX_W-1:0]  beat_q, beat_d;
   logic              ptr_q, ptr_d;
   logic              sh_a_vld_q, sh_a_vld_d;
   logic              sh_b_vld_q, sh_b_vld_d;
   logic              swap_ack_q, swap_ack_d;
   word_t             a_q [2][NS];
   word_t             a_d [2][NS];
   word_t             b_q [2][NS];
   word_t             b_d [2][NS];
   word_t             m_q [NS];
   word_t             m_d [NS];
   word_t             mp_q [N];
   word_t             mp_d [N];
   word_t             stg_q [NS];
   word_t             stg_d [NS];
   word_t             obuf_q [NS];
   word_t             obuf_d [NS];
   logic [RCNT_W-1:0] rcnt_q, rcnt_d;
   logic [IDX_W-1:0]  oidx_q, oidx_d;
   logic              ovalid_q, ovalid_d;

   logic              in_ready_c;
   logic              in_acc_c;
   logic [1:0]        eff_sel_c;
   logic              frame_last_c;
   logic              swap_do_c;
   logic              res_acc_c;
   logic              stg_done_c;
   logic              out_acc_c;
   logic              out_end_c;

   // State register for every storage element, counter and flag.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         beat_q     <= '0;
         ptr_q      <= 1'b0;
         sh_a_vld_q <= 1'b0;
         sh_b_vld_q <= 1'b0;
         swap_ack_q <= 1'b0;
         a_q        <= '{default: '0};
         b_q        <= '{default: '0};
         m_q        <= '{default: '0};
         mp_q       <= '{default: '0};
         stg_q      <= '{default: '0};
         obuf_q     <= '{default: '0};
         rcnt_q     <= '0;
         oidx_q     <= '0;
         ovalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         beat_q     <= beat_d;
         ptr_q      <= ptr_d;
         sh_a_vld_q <= sh_a_vld_d;
         sh_b_vld_q <= sh_b_vld_d;
         swap_ack_q <= swap_ack_d;
         a_q        <= a_d;
         b_q        <= b_d;
         m_q        <= m_d;
         mp_q       <= mp_d;
         stg_q      <= stg_d;
         obuf_q     <= obuf_d;
         rcnt_q     <= rcnt_d;
         oidx_q     <= oidx_d;
         ovalid_q   <= ovalid_d;
      end
   end

   // Load FSM: frame target latched on the first beat, word counter, backpressure.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      beat_d       = beat_q;
      in_ready_c   = 1'b1;
      eff_sel_c    = (state_q == ST_IDLE) ? bus.in_sel : sel_q;
      frame_last_c = (beat_q == ((eff_sel_c == SEL_MP) ? IDX_W'(N - 1) : IDX_W'(NS - 1)));
      if (state_q == ST_IDLE) begin
         if ((bus.in_sel == SEL_A && sh_a_vld_q) || (bus.in_sel == SEL_B && sh_b_vld_q)) begin
            in_ready_c = 1'b0;
         end
      end
      in_acc_c = bus.in_valid && in_ready_c;
      if (in_acc_c) begin
         if (state_q == ST_IDLE) begin
            sel_d = bus.in_sel;
         end
         if (frame_last_c) begin
            state_d = ST_IDLE;
            beat_d  = '0;
         end else begin
            state_d = ST_LOAD;
            beat_d  = beat_q + IDX_W'(1);
         end
      end
   end

   // Shadow-complete flags, bank pointer and swap acknowledge.
   always_comb begin
      swap_do_c  = swap_i && sh_a_vld_q && sh_b_vld_q;
      ptr_d      = ptr_q ^ swap_do_c;
      swap_ack_d = swap_do_c;
      sh_a_vld_d = sh_a_vld_q;
      sh_b_vld_d = sh_b_vld_q;
      if (swap_do_c) begin
         sh_a_vld_d = 1'b0;
         sh_b_vld_d = 1'b0;
      end
      if (in_acc_c && frame_last_c && eff_sel_c == SEL_A) begin
         sh_a_vld_d = 1'b1;
      end
      if (in_acc_c && frame_last_c && eff_sel_c == SEL_B) begin
         sh_b_vld_d = 1'b1;
      end
   end

   // Operand storage: datapath ops on the active bank, host writes to shadow / M / M'.
   always_comb begin
      a_d  = a_q;
      b_d  = b_q;
      m_d  = m_q;
      mp_d = mp_q;
      if (!swap_do_c) begin
         for (int j = 0; j < int'(S); j++) begin
            if (A_reg_coeff_rot_i[j]) begin
               for (int i = 0; i < int'(N); i++) begin
                  a_d[ptr_q][IDX_W'(int'(N) * j + i)] =
                     a_q[ptr_q][IDX_W'(int'(N) * j + ((i + 1) % int'(N)))];
               end
            end
         end
         if (B_reg_shift_i) begin
            for (int k = 0; k < int'(NS) - 1; k++) begin
               b_d[ptr_q][IDX_W'(k)] = b_q[ptr_q][IDX_W'(k + 1)];
            end
            b_d[ptr_q][IDX_W'(NS - 1)] = '0;
         end
         if (M_reg_rot_i) begin
            for (int k = 0; k < int'(NS); k++) begin
               m_d[IDX_W'(k)] = m_q[IDX_W'((k + 1) % int'(NS))];
            end
         end
         if (M_prime_0_rot_i) begin
            for (int k = 0; k < int'(N); k++) begin
               mp_d[MP_W'(k)] = mp_q[MP_W'((k + 1) % int'(N))];
            end
         end
      end
      if (in_acc_c) begin
         case (eff_sel_c)
            SEL_A:   a_d[~ptr_q][beat_q] = bus.in_data;
            SEL_B:   b_d[~ptr_q][beat_q] = bus.in_data;
            SEL_M:   m_d[beat_q]         = bus.in_data;
            SEL_MP:  mp_d[MP_W'(beat_q)] = bus.in_data;
            default: ;
         endcase
      end
   end

   // Result staging (block-interleaved) and output buffer streaming.
   always_comb begin
      stg_d      = stg_q;
      obuf_d     = obuf_q;
      rcnt_d     = rcnt_q;
      oidx_d     = oidx_q;
      ovalid_d   = ovalid_q;
      res_acc_c  = res_load_en_i && (rcnt_q != RCNT_W'(S));
      if (res_acc_c) begin
         for (int i = 0; i < int'(N); i++) begin
            stg_d[IDX_W'(i * int'(S)) + IDX_W'(rcnt_q)] = res_din_i[i*WORD_WIDTH +: WORD_WIDTH];
         end
         rcnt_d = rcnt_q + RCNT_W'(1);
      end
      stg_done_c = (rcnt_q == RCNT_W'(S)) || (res_acc_c && rcnt_q == RCNT_W'(S - 1));
      out_acc_c  = ovalid_q && bus.out_ready;
      out_end_c  = out_acc_c && (oidx_q == IDX_W'(NS - 1));
      if (out_acc_c) begin
         oidx_d = out_end_c ? '0 : oidx_q + IDX_W'(1);
         if (out_end_c) begin
            ovalid_d = 1'b0;
         end
      end
      // A completed staging buffer moves as soon as the output buffer frees up.
      if (stg_done_c && (!ovalid_q || out_end_c)) begin
         obuf_d   = stg_d;
         rcnt_d   = '0;
         ovalid_d = 1'b1;
         oidx_d   = '0;
      end
   end

   // Active-bank read taps.
   always_comb begin
      A_reg_dout_o = '0;
      B_reg_dout_o = '0;
      for (int j = 0; j < int'(S); j++) begin
         A_reg_dout_o[j*WORD_WIDTH +: WORD_WIDTH] = a_q[ptr_q][IDX_W'(int'(N) * j)];
      end
      for (int l = 0; l < int'(N); l++) begin
         B_reg_dout_o[l*WORD_WIDTH +: WORD_WIDTH] = b_q[ptr_q][IDX_W'(l * int'(S))];
      end
   end

   assign M_reg_dout_o         = m_q[0];
   assign M_prime_0_reg_dout_o = mp_q[0];
   assign shadow_full_o        = sh_a_vld_q && sh_b_vld_q;
   assign swap_ack_o           = swap_ack_q;
   assign res_ready_o          = (rcnt_q != RCNT_W'(S));
   assign bus.in_ready         = in_ready_c;
   assign bus.out_valid        = ovalid_q;
   assign bus.out_data         = obuf_q[oidx_q];
   assign bus.out_last         = ovalid_q && (oidx_q == IDX_W'(NS - 1));

endmodule
